// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-RAM boot loader.
// Imported by the loader top and its byte packer.
package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 12;
    localparam int IMEM_WORD_BYTES = 4;
    localparam int IMEM_BCNT_W     = $clog2(IMEM_WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DRAIN,
        DONE,
        ERR
    } loader_state_e;

    function automatic logic [31:0] word_byte_addr(
        input logic [31:0] base,
        input logic [29:0] idx
    );
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the header and payload phases.
// word is combinational so the 4th byte is usable in the cycle it arrives.
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [IMEM_BCNT_W-1:0] cnt;
    logic [23:0]            acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + IMEM_BCNT_W'(1);
            unique case (cnt)
                2'd0:    acc[7:0]   <= data;
                2'd1:    acc[15:8]  <= data;
                2'd2:    acc[23:16] <= data;
                default: ;
            endcase
        end
    end

    assign word       = {data, acc};
    assign word_valid = en && (cnt == IMEM_BCNT_W'(IMEM_WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: unpacks a length-prefixed byte stream into IRAM words
// and holds the core in reset until the image is complete.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   word_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_rst_n
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    loader_state_e state;
    loader_state_e state_next;

    logic        xfer;
    logic        start_ok;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic [31:0] len;
    logic [31:0] cnt_plus1;
    logic        last_word;
    logic        len_zero;
    logic        len_over;

    // rx_ready comes from the state register alone, never from rx_valid
    assign rx_ready = (state == LEN) || (state == DATA);
    assign xfer     = rx_valid && rx_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE) ||
                                (state == ERR));

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .en         (xfer),
        .data       (rx_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign cnt_plus1 = {{(31 - ADDR_WIDTH){1'b0}}, word_cnt} + 32'd1;
    assign last_word = (cnt_plus1 == len);
    assign len_zero  = (pk_word == 32'd0);
    assign len_over  = ({1'b0, pk_word} > DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = LEN;
            end
            LEN: begin
                busy = 1'b1;
                if (pk_valid) begin
                    if (len_zero)      state_next = DONE;
                    else if (len_over) state_next = ERR;
                    else               state_next = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (pk_valid && last_word) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                if (start) state_next = LEN;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = LEN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                word_cnt <= '0;
            end
            if ((state == LEN) && pk_valid) begin
                len <= pk_word;
            end
            // the write lands one cycle after the word's 4th byte
            if ((state == DATA) && pk_valid) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_byte_addr(BASE_ADDR,
                                 {{(29 - ADDR_WIDTH){1'b0}}, word_cnt});
                mem_wdata <= pk_word;
                word_cnt  <= word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
        end
    end

endmodule
